corr_search_sequencer: RTL
==========================

Name: corr_search_sequencer

Overview:
Bus-master sequencer that drives one spread-spectrum correlator channel through a code-phase search. It programs the channel's DDS and PRN registers over the correlator register bus and starts the global run. For each phase hypothesis it collects one correlation dump, compares the dump's magnitude against a threshold, and steps the chip phase until a hit is found or the step budget is exhausted. It sits between the host configuration logic and the correlator's addr/Wdata/write/read/Rdata port.

Parameters:
FREQ_BASE, 32'hFE000300, frequency DDS block base (+0x10 add, +0x14 phase, +0x1C control)
CHIP_BASE, 32'hFE000500, chip DDS block base (+0x10 freq, +0x14 phase, +0x18 phase adjust, +0x1C PRN)
CORR_BASE, 32'hFE000700, correlation block base (+0x14 low, +0x18 high, +0x1C status)
RUN_ADDR, 32'hFE000100, global run register
TIMEOUT, 1000000, max cycles waiting for one dump

Ports:
clk  input  1  clock
rst  input  1  reset
start  input  1  start pulse; latches all cfg_* inputs
abort  input  1  abort pulse
cfg_freq_add  input  32  frequency DDS increment
cfg_chip_freq  input  32  chip DDS increment
cfg_prn  input  32  PRN register word {hob[3:0], poly[13:0], seed[13:0]}
cfg_step  input  32  chip phase adjust per hypothesis
cfg_num_steps  input  16  hypotheses to test; 0 is treated as 1
cfg_threshold  input  64  unsigned magnitude threshold
m_addr  output  32  correlator bus address
m_wdata  output  32  correlator bus write data
m_write  output  1  bus write strobe, one cycle per access
m_read  output  1  bus read strobe, one cycle per access
m_rdata  input  32  bus read data; combinational, valid in the same cycle as m_read
corr_seen  input  1  channel dump-ready flag; cleared by a status read
busy  output  1  high from the cycle after an accepted start until the done pulse
done  output  1  one-cycle completion pulse
found  output  1  a hit met the threshold; valid from done until the next start
timeout_err  output  1  search ended on timeout
best_step  output  16  hypothesis index with the largest magnitude
best_mag  output  64  largest magnitude seen
cur_step  output  16  hypothesis currently under test

Behaviour:
- Interface: one clock, clk; rst is synchronous and active-high.
- Reset: all outputs are 0, the FSM is in IDLE, and both bus strobes are low.
- At most one bus strobe is high in any cycle. m_addr and m_wdata are 0 when no strobe is high.
- FSM states: IDLE, CFG, WAIT, RD_LO, RD_HI, RD_ST, EVAL, ADJ, DISCARD, STOP, DONE.
- IDLE: on start (with abort low), latch the cfg_* inputs, clear best_mag, best_step, cur_step, found and timeout_err, then go to CFG.
- start is ignored while busy. If start and abort are high together in IDLE, both are ignored.
- CFG issues 7 consecutive writes, one per cycle, in this order:
  - FREQ+0x10 = freq_add
  - FREQ+0x14 = 0
  - CHIP+0x10 = chip_freq
  - CHIP+0x14 = 0
  - CHIP+0x1C = prn
  - FREQ+0x1C = 1
  - RUN_ADDR = 1
  After the last write, go to WAIT.
- WAIT: count cycles until corr_seen is high, then go to RD_LO. If the count reaches TIMEOUT, set timeout_err and go to STOP.
- RD_LO, RD_HI, RD_ST: one read each of CORR+0x14, CORR+0x18 and CORR+0x1C. The low and high words are captured into a signed 64-bit value. The status read clears corr_seen in the channel.
- EVAL:
  - mag = |value| as unsigned 64-bit; the value -2^63 gives 2^63.
  - If mag > best_mag (strictly greater), update best_mag and best_step = cur_step, so the first occurrence wins ties.
  - If mag >= threshold, set found and go to STOP.
  - Else if cur_step == num_steps-1, go to STOP.
  - Else increment cur_step and go to ADJ.
- ADJ: write CHIP+0x18 = step, then go to DISCARD.
- DISCARD: wait for corr_seen (same timeout rule as WAIT), read CORR+0x1C once to drop the dump that straddles the adjust, then go to WAIT.
- STOP: write RUN_ADDR = 0, then go to DONE.
- DONE: pulse done for one cycle, return to IDLE. found, timeout_err, best_* and cur_step hold until the next accepted start.
- abort in any busy state goes to STOP on the next cycle, completing any strobe already issued in the current cycle. found is forced to 0.
- The timeout counter is 32-bit and resets on every entry to WAIT or DISCARD.
- rst mid-search: the search is lost immediately and no further bus access is issued. The channel is not stopped; host software rewrites RUN_ADDR.

Test Plan:
- Reset: assert rst for 2 cycles mid-CFG -> next cycle all outputs are 0, m_write=0, and no further bus access occurs.
- Config: start with freq_add=0x1000, chip_freq=0x2000, prn=0x12345678 -> exactly 7 consecutive write cycles with the addresses and data listed above, then no strobe until corr_seen.
- Hit: threshold=500; the channel model returns magnitude 10 on steps 0 and 1 and value -1000 (hi=0xFFFFFFFF, lo=0xFFFFFC18) on step 2 -> found=1, best_step=2, best_mag=1000, two writes of 0x518 with data=step, write 0x100=0, then a done pulse.
- Miss: num_steps=4, threshold=100, magnitudes 5, 9, 9, 7 -> found=0, best_step=1, best_mag=9, three ADJ writes, three discard status reads.
- Timeout: TIMEOUT=50, corr_seen held low -> 50 cycles after entering WAIT, timeout_err=1, write 0x100=0, done pulse.
- Abort and busy start: abort during WAIT -> next cycle write 0x100=0, then done with found=0. A start pulse issued while busy has no effect.

Source files
------------

// File: rtl/corr_search_sequencer.sv
// Code-phase search sequencer: programs one correlator channel, collects dumps per
// chip-phase hypothesis and stops on a threshold hit, step exhaustion, timeout or abort.
module corr_search_sequencer #(
    parameter logic [31:0] FREQ_BASE = 32'hFE000300,
    parameter logic [31:0] CHIP_BASE = 32'hFE000500,
    parameter logic [31:0] CORR_BASE = 32'hFE000700,
    parameter logic [31:0] RUN_ADDR  = 32'hFE000100,
    parameter int unsigned TIMEOUT   = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] cfg_freq_add,
    input  logic [31:0] cfg_chip_freq,
    input  logic [31:0] cfg_prn,
    input  logic [31:0] cfg_step,
    input  logic [15:0] cfg_num_steps,
    input  logic [63:0] cfg_threshold,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic        m_write,
    output logic        m_read,
    input  logic [31:0] m_rdata,
    input  logic        corr_seen,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic        timeout_err,
    output logic [15:0] best_step,
    output logic [63:0] best_mag,
    output logic [15:0] cur_step
);

    // state   | meaning
    // IDLE    | waiting for start
    // CFG     | 7 setup writes, cfg_idx selects the register
    // WAIT    | waiting for a dump, timeout armed
    // RD_LO   | read dump low word
    // RD_HI   | read dump high word
    // RD_ST   | read status (clears corr_seen)
    // EVAL    | magnitude compare, pick next action
    // ADJ     | write chip phase adjust
    // DISCARD | drop the dump straddling the adjust
    // STOP    | write RUN_ADDR = 0
    // DONE    | one-cycle done pulse
    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_CFG     = 4'd1;
    localparam logic [3:0] S_WAIT    = 4'd2;
    localparam logic [3:0] S_RD_LO   = 4'd3;
    localparam logic [3:0] S_RD_HI   = 4'd4;
    localparam logic [3:0] S_RD_ST   = 4'd5;
    localparam logic [3:0] S_EVAL    = 4'd6;
    localparam logic [3:0] S_ADJ     = 4'd7;
    localparam logic [3:0] S_DISCARD = 4'd8;
    localparam logic [3:0] S_STOP    = 4'd9;
    localparam logic [3:0] S_DONE    = 4'd10;

    localparam logic [31:0] TMR_LOAD = 32'(TIMEOUT - 1);

    logic [3:0]  state;
    logic [2:0]  cfg_idx;
    logic [31:0] tmr;
    logic [31:0] freq_add_r;
    logic [31:0] chip_freq_r;
    logic [31:0] prn_r;
    logic [31:0] step_r;
    logic [15:0] last_step_r;
    logic [63:0] threshold_r;
    logic [31:0] val_lo;
    logic [31:0] val_hi;
    logic [63:0] dump_val;
    logic [63:0] mag;

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // Two's-complement negate in 64 bits maps -2^63 onto 2^63 as an unsigned value.
    always_comb begin
        dump_val = {val_hi, val_lo};
        mag      = dump_val[63] ? (~dump_val + 64'd1) : dump_val;
    end

    always_comb begin
        m_addr  = 32'd0;
        m_wdata = 32'd0;
        m_write = 1'b0;
        m_read  = 1'b0;
        if (!rst) begin
            case (state)
                S_CFG: begin
                    m_write = 1'b1;
                    case (cfg_idx)
                        3'd0: begin m_addr = FREQ_BASE + 32'h10; m_wdata = freq_add_r;  end
                        3'd1: begin m_addr = FREQ_BASE + 32'h14; m_wdata = 32'd0;       end
                        3'd2: begin m_addr = CHIP_BASE + 32'h10; m_wdata = chip_freq_r; end
                        3'd3: begin m_addr = CHIP_BASE + 32'h14; m_wdata = 32'd0;       end
                        3'd4: begin m_addr = CHIP_BASE + 32'h1C; m_wdata = prn_r;       end
                        3'd5: begin m_addr = FREQ_BASE + 32'h1C; m_wdata = 32'd1;       end
                        default: begin m_addr = RUN_ADDR; m_wdata = 32'd1; end
                    endcase
                end
                S_RD_LO: begin
                    m_read = 1'b1;
                    m_addr = CORR_BASE + 32'h14;
                end
                S_RD_HI: begin
                    m_read = 1'b1;
                    m_addr = CORR_BASE + 32'h18;
                end
                S_RD_ST: begin
                    m_read = 1'b1;
                    m_addr = CORR_BASE + 32'h1C;
                end
                S_ADJ: begin
                    m_write = 1'b1;
                    m_addr  = CHIP_BASE + 32'h18;
                    m_wdata = step_r;
                end
                S_DISCARD: begin
                    // status read is issued in the same cycle the dump flag is seen
                    if (corr_seen) begin
                        m_read = 1'b1;
                        m_addr = CORR_BASE + 32'h1C;
                    end
                end
                S_STOP: begin
                    m_write = 1'b1;
                    m_addr  = RUN_ADDR;
                    m_wdata = 32'd0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cfg_idx     <= 3'd0;
            tmr         <= 32'd0;
            freq_add_r  <= 32'd0;
            chip_freq_r <= 32'd0;
            prn_r       <= 32'd0;
            step_r      <= 32'd0;
            last_step_r <= 16'd0;
            threshold_r <= 64'd0;
            val_lo      <= 32'd0;
            val_hi      <= 32'd0;
            found       <= 1'b0;
            timeout_err <= 1'b0;
            best_step   <= 16'd0;
            best_mag    <= 64'd0;
            cur_step    <= 16'd0;
        end else if (state == S_IDLE) begin
            if (start && !abort) begin
                freq_add_r  <= cfg_freq_add;
                chip_freq_r <= cfg_chip_freq;
                prn_r       <= cfg_prn;
                step_r      <= cfg_step;
                last_step_r <= (cfg_num_steps == 16'd0) ? 16'd0 : cfg_num_steps - 16'd1;
                threshold_r <= cfg_threshold;
                found       <= 1'b0;
                timeout_err <= 1'b0;
                best_step   <= 16'd0;
                best_mag    <= 64'd0;
                cur_step    <= 16'd0;
                cfg_idx     <= 3'd0;
                state       <= S_CFG;
            end
        end else if (abort && state != S_DONE) begin
            found <= 1'b0;
            state <= (state == S_STOP) ? S_DONE : S_STOP;
        end else begin
            case (state)
                S_CFG: begin
                    if (cfg_idx == 3'd6) begin
                        tmr   <= TMR_LOAD;
                        state <= S_WAIT;
                    end else begin
                        cfg_idx <= cfg_idx + 3'd1;
                    end
                end
                S_WAIT: begin
                    if (corr_seen) begin
                        state <= S_RD_LO;
                    end else if (tmr == 32'd0) begin
                        timeout_err <= 1'b1;
                        state       <= S_STOP;
                    end else begin
                        tmr <= tmr - 32'd1;
                    end
                end
                S_RD_LO: begin
                    val_lo <= m_rdata;
                    state  <= S_RD_HI;
                end
                S_RD_HI: begin
                    val_hi <= m_rdata;
                    state  <= S_RD_ST;
                end
                S_RD_ST: state <= S_EVAL;
                S_EVAL: begin
                    if (mag > best_mag) begin
                        best_mag  <= mag;
                        best_step <= cur_step;
                    end
                    if (mag >= threshold_r) begin
                        found <= 1'b1;
                        state <= S_STOP;
                    end else if (cur_step == last_step_r) begin
                        state <= S_STOP;
                    end else begin
                        cur_step <= cur_step + 16'd1;
                        state    <= S_ADJ;
                    end
                end
                S_ADJ: begin
                    tmr   <= TMR_LOAD;
                    state <= S_DISCARD;
                end
                S_DISCARD: begin
                    if (corr_seen) begin
                        tmr   <= TMR_LOAD;
                        state <= S_WAIT;
                    end else if (tmr == 32'd0) begin
                        timeout_err <= 1'b1;
                        state       <= S_STOP;
                    end else begin
                        tmr <= tmr - 32'd1;
                    end
                end
                S_STOP: state <= S_DONE;
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
